// File: rtl/fp_cmp_unit.sv
// -----------------------------------------------------------------------------
// fp_cmp_unit
//
// Two-stage pipelined single-precision compare / min / max unit covering
// FEQ.S, FLT.S, FLE.S, FMIN.S and FMAX.S. Operand classification is taken from
// the upstream classify stage as one-hot FCLASS vectors rather than re-decoded.
//
// Optional feature macro: FP_CMP_NV_STICKY_EN
//   defined   -> o_nv_sticky accumulates delivered NV flags, cleared by i_nv_clr
//   undefined -> o_nv_sticky is tied 0 and i_nv_clr is ignored
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_flush            drop every in-flight operation (highest priority)
//   i_valid / o_ready  input handshake
//   i_op               000 FLE, 001 FLT, 010 FEQ, 100 FMIN, 101 FMAX
//   i_rs1_f, i_rs2_f   IEEE-754 single operands
//   i_cls1, i_cls2     one-hot FCLASS vectors (bit0 -inf ... bit9 qNaN)
//   i_tag              destination tag, returned unchanged as o_tag
//   o_valid / i_ready  output handshake
//   o_result, o_nv     result word and invalid-operation flag
//   o_nv_sticky        accumulated NV flag
//   i_nv_clr           clears o_nv_sticky
// -----------------------------------------------------------------------------
module fp_cmp_unit #(
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [31:0]      i_rs1_f,
    input  logic [31:0]      i_rs2_f,
    input  logic [9:0]       i_cls1,
    input  logic [9:0]       i_cls2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic             o_nv,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_nv_sticky,
    input  logic             i_nv_clr
);

    localparam logic [2:0] OP_FLE  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b100;
    localparam logic [2:0] OP_FMAX = 3'b101;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Stage S1 registers (index 0 = rs1, index 1 = rs2)
    logic                  s1_valid_reg, s1_valid_next;
    logic [2:0]            s1_op_reg;
    logic [1:0][31:0]      s1_rs_reg;
    logic [1:0][9:0]       s1_cls_reg;
    logic [TAG_W-1:0]      s1_tag_reg;

    // Stage S2 (output) registers
    logic                  s2_valid_reg, s2_valid_next;
    logic [31:0]           s2_result_reg, s2_result_next;
    logic                  s2_nv_reg, s2_nv_next;
    logic [TAG_W-1:0]      s2_tag_reg;

    logic s2_take;
    logic s2_load;
    logic accept;

    // S2 frees up when empty or being drained this cycle; S1 frees up when
    // empty or moving into S2. This gives full throughput under i_ready = 1.
    assign s2_take = !s2_valid_reg || i_ready;
    assign o_ready = !s1_valid_reg || s2_take;
    assign accept  = i_valid && o_ready;
    assign s2_load = s2_take && s1_valid_reg;

    always_comb begin
        s1_valid_next = s1_valid_reg;
        s2_valid_next = s2_valid_reg;
        if (s2_take) begin
            s2_valid_next = s1_valid_reg;
        end
        if (o_ready) begin
            s1_valid_next = accept;
        end
        if (i_flush) begin
            s1_valid_next = 1'b0;
            s2_valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
        end
    end

    // S1 data loads only on accept so a stalled entry is preserved.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_op_reg  <= '0;
            s1_rs_reg  <= '0;
            s1_cls_reg <= '0;
            s1_tag_reg <= '0;
        end else if (accept) begin
            s1_op_reg  <= i_op;
            s1_rs_reg  <= {i_rs2_f, i_rs1_f};
            s1_cls_reg <= {i_cls2, i_cls1};
            s1_tag_reg <= i_tag;
        end
    end

    // Per-operand class flags
    logic [1:0] is_nan, is_snan, is_zero;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            assign is_nan[gi]  = s1_cls_reg[gi][8] | s1_cls_reg[gi][9];
            assign is_snan[gi] = s1_cls_reg[gi][8];
            assign is_zero[gi] = s1_cls_reg[gi][3] | s1_cls_reg[gi][4];
        end
    endgenerate

    // Class bits not needed for compare/min/max
    logic unused_cls_bits;
    assign unused_cls_bits = ^{s1_cls_reg[0][7:5], s1_cls_reg[0][2:0],
                               s1_cls_reg[1][7:5], s1_cls_reg[1][2:0]};

    logic [31:0] a_f, b_f;
    logic        any_nan, any_snan, both_zero;
    logic        eq, lt, lt_raw;
    logic [31:0] min_sel, max_sel;

    assign a_f       = s1_rs_reg[0];
    assign b_f       = s1_rs_reg[1];
    assign any_nan   = |is_nan;
    assign any_snan  = |is_snan;
    assign both_zero = &is_zero;
    assign eq        = (a_f == b_f) || both_zero;

    // lt_raw is a pure sign-magnitude order in which -0 sits below +0; that
    // is exactly the ordering min/max needs. The compare ops mask the zero
    // case so that -0 and +0 are unordered-equal.
    always_comb begin
        lt_raw = 1'b0;
        if (a_f[31] != b_f[31]) begin
            lt_raw = a_f[31];
        end else if (!a_f[31]) begin
            lt_raw = a_f[30:0] < b_f[30:0];
        end else begin
            lt_raw = a_f[30:0] > b_f[30:0];
        end
    end

    assign lt      = lt_raw && !both_zero;
    assign min_sel = lt_raw ? a_f : b_f;
    assign max_sel = lt_raw ? b_f : a_f;

    always_comb begin
        s2_result_next = '0;
        s2_nv_next     = 1'b0;
        case (s1_op_reg)
            OP_FEQ: begin
                s2_result_next = {31'b0, eq && !any_nan};
                s2_nv_next     = any_snan;
            end
            OP_FLT: begin
                s2_result_next = {31'b0, lt && !any_nan};
                s2_nv_next     = any_nan;
            end
            OP_FLE: begin
                s2_result_next = {31'b0, (lt || eq) && !any_nan};
                s2_nv_next     = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                s2_nv_next = any_snan;
                if (&is_nan) begin
                    s2_result_next = CANON_NAN;
                end else if (is_nan[0]) begin
                    s2_result_next = b_f;
                end else if (is_nan[1]) begin
                    s2_result_next = a_f;
                end else begin
                    s2_result_next = (s1_op_reg == OP_FMIN) ? min_sel : max_sel;
                end
            end
            default: begin
                s2_result_next = '0;
                s2_nv_next     = 1'b0;
            end
        endcase
    end

    // Output registers hold while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_result_reg <= '0;
            s2_nv_reg     <= 1'b0;
            s2_tag_reg    <= '0;
        end else if (s2_load) begin
            s2_result_reg <= s2_result_next;
            s2_nv_reg     <= s2_nv_next;
            s2_tag_reg    <= s1_tag_reg;
        end
    end

    assign o_valid  = s2_valid_reg;
    assign o_result = s2_result_reg;
    assign o_nv     = s2_nv_reg;
    assign o_tag    = s2_tag_reg;

`ifdef FP_CMP_NV_STICKY_EN
    logic nv_sticky_reg;

    // Set beats clear; a result sitting at the output during a flush counts
    // as flushed and does not set the flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            nv_sticky_reg <= 1'b0;
        end else if (s2_valid_reg && i_ready && s2_nv_reg && !i_flush) begin
            nv_sticky_reg <= 1'b1;
        end else if (i_nv_clr) begin
            nv_sticky_reg <= 1'b0;
        end
    end

    assign o_nv_sticky = nv_sticky_reg;
`else
    logic unused_nv_clr;
    assign unused_nv_clr = i_nv_clr;
    assign o_nv_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_cmp_unit.sv
// -----------------------------------------------------------------------------
// Testbench for fp_cmp_unit: directed cases, backpressure, flush, reset and a
// randomized phase, all checked against a value-ordering reference model and a
// FIFO scoreboard of expected results.
// -----------------------------------------------------------------------------
module tb_fp_cmp_unit;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [2:0]       in_op;
    logic [31:0]      rs1, rs2;
    logic [9:0]       cls1, cls2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             in_ready;
    logic [31:0]      out_result;
    logic             out_nv;
    logic [TAG_W-1:0] out_tag;
    logic             out_sticky;
    logic             nv_clr;

    fp_cmp_unit #(.TAG_W(TAG_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .i_op        (in_op),
        .i_rs1_f     (rs1),
        .i_rs2_f     (rs2),
        .i_cls1      (cls1),
        .i_cls2      (cls2),
        .i_tag       (in_tag),
        .o_valid     (out_valid),
        .i_ready     (in_ready),
        .o_result    (out_result),
        .o_nv        (out_nv),
        .o_tag       (out_tag),
        .o_nv_sticky (out_sticky),
        .i_nv_clr    (nv_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      r;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   del_cnt  = 0;
    logic sticky_model = 1'b0;
    // Values sampled at the falling edge by cycle()
    logic s_ready, s_valid, s_del;

    // ---------------- reference model ----------------
    function automatic logic [9:0] classify(input logic [31:0] x);
        logic [9:0] c;
        c = '0;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 0) c[x[22] ? 9 : 8] = 1'b1;
            else              c[x[31] ? 0 : 7] = 1'b1;
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 0) c[x[31] ? 3 : 4] = 1'b1;
            else              c[x[31] ? 2 : 5] = 1'b1;
        end else begin
            c[x[31] ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    function automatic logic is_nan_f(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic logic is_snan_f(input logic [31:0] x);
        return is_nan_f(x) && !x[22];
    endfunction

    // Signed ordering key: equal keys mean numerically equal (both zeros -> 0).
    function automatic longint key(input logic [31:0] x);
        longint m;
        m = longint'({33'b0, x[30:0]});
        if (m == 0) return 0;
        return x[31] ? -m : m;
    endfunction

    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [TAG_W-1:0] t);
        exp_t   e;
        logic   na, nb, sn;
        longint ka, kb;
        na = is_nan_f(a);
        nb = is_nan_f(b);
        sn = is_snan_f(a) || is_snan_f(b);
        ka = key(a);
        kb = key(b);
        e.tag = t;
        e.r   = 32'h0;
        e.nv  = 1'b0;
        case (op)
            3'b010: begin e.r = {31'b0, !(na || nb) && (ka == kb)}; e.nv = sn; end
            3'b001: begin e.r = {31'b0, !(na || nb) && (ka < kb)};  e.nv = na || nb; end
            3'b000: begin e.r = {31'b0, !(na || nb) && (ka <= kb)}; e.nv = na || nb; end
            3'b100, 3'b101: begin
                e.nv = sn;
                if (na && nb)        e.r = 32'h7FC00000;
                else if (na)         e.r = b;
                else if (nb)         e.r = a;
                else if (ka != kb)   e.r = ((ka < kb) == (op == 3'b100)) ? a : b;
                else if (a[31] != b[31])
                    // -0 vs +0: min takes the negative one, max the positive one
                    e.r = ((op == 3'b100) == a[31]) ? a : b;
                else                 e.r = a;
            end
            default: begin e.r = 32'h0; e.nv = 1'b0; end
        endcase
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        nv_clr   = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
        in_op    = op;
        rs1      = a;
        rs2      = b;
        cls1     = classify(a);
        cls2     = classify(b);
        in_tag   = t;
        in_valid = 1'b1;
    endtask

    // One clock: bookkeeping at the falling edge, then advance to just after
    // the next rising edge and check the sticky flag.
    task automatic cycle(output logic acc);
        exp_t e;
        logic del, dnv;
        @(negedge clk);
        s_ready = out_ready;
        s_valid = out_valid;
        acc = in_valid && out_ready;
        del = out_valid && in_ready;
        s_del = del;
        dnv = 1'b0;
        if (del) begin
            if (q.size() == 0) begin
                check("unexpected_delivery", {31'b0, out_valid}, 32'h0);
            end else begin
                e = q.pop_front();
                dnv = e.nv;
                check("deliver_result", out_result, e.r);
                check("deliver_nv", {31'b0, out_nv}, {31'b0, e.nv});
                check("deliver_tag", {27'b0, out_tag}, {27'b0, e.tag});
                $display("deliver tag=%0d result=%08h nv=%0b", out_tag, out_result, out_nv);
                del_cnt++;
            end
        end
`ifdef FP_CMP_NV_STICKY_EN
        if (del && dnv && !flush) sticky_model = 1'b1;
        else if (nv_clr)          sticky_model = 1'b0;
`endif
        if (flush)    q.delete();
        else if (acc) q.push_back(ref_model(in_op, rs1, rs2, in_tag));
        @(posedge clk);
        #1;
        check("sticky", {31'b0, out_sticky}, {31'b0, sticky_model});
    endtask

    // Single op with i_ready held high: checks 2-cycle latency and the value.
    task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] t,
                            input logic [31:0] exp_r, input logic exp_nv);
        logic acc;
        in_ready = 1'b1;
        issue(op, a, b, t);
        cycle(acc);
        check({name, "_accept"}, {31'b0, acc}, 32'h1);
        in_valid = 1'b0;
        check({name, "_lat1"}, {31'b0, out_valid}, 32'h0);
        cycle(acc);
        check({name, "_lat2"}, {31'b0, out_valid}, 32'h1);
        check({name, "_r"}, out_result, exp_r);
        check({name, "_nv"}, {31'b0, out_nv}, {31'b0, exp_nv});
        check({name, "_tag"}, {27'b0, out_tag}, {27'b0, t});
        cycle(acc);
    endtask

    function automatic logic [31:0] rnd_f(input logic [31:0] other);
        logic [31:0] pool [13];
        pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                 32'hFFC00001, 32'h7F800001, 32'hFFA00000, 32'h3F800000, 32'hBF800000,
                 32'h00000001, 32'h80000001, 32'h7F7FFFFF};
        case ($urandom_range(0, 9))
            0, 1, 2: return pool[$urandom_range(0, 12)];
            3:       return other;
            4:       return other ^ 32'h80000000;
            5:       return other + 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        logic [31:0] held_r;
        logic [2:0] ops [8];
        int base;
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        rst_n = 1'b0;
        in_ready = 1'b0;
        idle();
        issue(3'b000, 32'h0, 32'h0, '0);
        in_valid = 1'b0;
        #3;
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_result", out_result, 32'h0);
        check("rst_nv", {31'b0, out_nv}, 32'h0);
        check("rst_tag", {27'b0, out_tag}, 32'h0);
        check("rst_sticky", {31'b0, out_sticky}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'b0, out_ready}, 32'h1);

        // Ordered compares, zeros, NaNs, min/max
        directed("flt_1_2",    3'b001, 32'h3F800000, 32'h40000000, 5'd1, 32'h1, 1'b0);
        directed("fle_2_1",    3'b000, 32'h40000000, 32'h3F800000, 5'd2, 32'h0, 1'b0);
        directed("feq_zeros",  3'b010, 32'h00000000, 32'h80000000, 5'd3, 32'h1, 1'b0);
        directed("feq_qnan",   3'b010, 32'h7FC00000, 32'h3F800000, 5'd4, 32'h0, 1'b0);
        directed("feq_snan",   3'b010, 32'h7F800001, 32'h3F800000, 5'd5, 32'h0, 1'b1);
        directed("flt_qnan",   3'b001, 32'h7FC00000, 32'h3F800000, 5'd6, 32'h0, 1'b1);
        directed("fmin_zeros", 3'b100, 32'h80000000, 32'h00000000, 5'd7, 32'h80000000, 1'b0);
        directed("fmax_zeros", 3'b101, 32'h80000000, 32'h00000000, 5'd8, 32'h00000000, 1'b0);
        directed("fmax_2nan",  3'b101, 32'h7FC00000, 32'h7FC00000, 5'd9, 32'h7FC00000, 1'b0);
        directed("fmin_snan",  3'b100, 32'h7F800001, 32'h40400000, 5'd10, 32'h40400000, 1'b1);
        directed("fle_equal",  3'b000, 32'h3F800000, 32'h3F800000, 5'd11, 32'h1, 1'b0);
        directed("flt_neg",    3'b001, 32'hBF800000, 32'hC0000000, 5'd12, 32'h0, 1'b0);
        directed("flt_neg2",   3'b001, 32'hC0000000, 32'hBF800000, 5'd13, 32'h1, 1'b0);
        directed("fmax_pz_nz", 3'b101, 32'h00000000, 32'h80000000, 5'd14, 32'h00000000, 1'b0);
        directed("illegal",    3'b011, 32'h3F800000, 32'h40000000, 5'd15, 32'h0, 1'b0);

`ifdef FP_CMP_NV_STICKY_EN
        directed("sticky_snan", 3'b010, 32'h7F800001, 32'h3F800000, 5'd16, 32'h0, 1'b1);
        check("sticky_set", {31'b0, out_sticky}, 32'h1);
        directed("sticky_clean", 3'b001, 32'h3F800000, 32'h40000000, 5'd17, 32'h1, 1'b0);
        check("sticky_hold", {31'b0, out_sticky}, 32'h1);
        nv_clr = 1'b1;
        cycle(acc);
        nv_clr = 1'b0;
        check("sticky_clr", {31'b0, out_sticky}, 32'h0);
        issue(3'b010, 32'h7F800001, 32'h3F800000, 5'd18);
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        nv_clr = 1'b1;
        cycle(acc);
        nv_clr = 1'b0;
        check("sticky_set_wins", {31'b0, out_sticky}, 32'h1);
`endif

        // Backpressure: tags 1..6 back to back, consumer stalled for 4 cycles
        base = del_cnt;
        begin
            int next_tag;
            next_tag = 1;
            held_r = '0;
            for (int c = 0; c < 12; c++) begin
                in_ready = (c >= 4);
                if (next_tag <= 6) issue(3'b101, $urandom, $urandom, next_tag[TAG_W-1:0]);
                else               in_valid = 1'b0;
                cycle(acc);
                if (acc) next_tag++;
                if (c < 2)  check("bp_ready_early", {31'b0, s_ready}, 32'h1);
                if (c == 2 || c == 3) begin
                    check("bp_ready_full", {31'b0, s_ready}, 32'h0);
                    check("bp_hold_tag", {27'b0, out_tag}, 32'h1);
                end
                if (c == 2) held_r = out_result;
                if (c == 3) check("bp_hold_result", out_result, held_r);
                if (c >= 4 && c <= 9) check("bp_stream", {31'b0, s_del}, 32'h1);
            end
            check("bp_count", del_cnt - base, 32'd6);
        end

        // Flush with both stages full and an op presented
        in_ready = 1'b0;
        issue(3'b000, 32'h3F800000, 32'h40000000, 5'd20);
        cycle(acc);
        issue(3'b001, 32'h3F800000, 32'h40000000, 5'd21);
        cycle(acc);
        issue(3'b010, 32'h3F800000, 32'h3F800000, 5'd22);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        // Flush while an op is being accepted into an empty pipeline
        in_ready = 1'b1;
        issue(3'b100, 32'h3F800000, 32'h40000000, 5'd23);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        base = del_cnt;
        for (int c = 0; c < 3; c++) begin
            cycle(acc);
            check("flush_empty", {31'b0, out_valid}, 32'h0);
        end
        issue(3'b101, 32'h3F800000, 32'h40000000, 5'd24);
        cycle(acc);
        issue(3'b100, 32'h3F800000, 32'h40000000, 5'd25);
        cycle(acc);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) cycle(acc);
        check("flush_after_count", del_cnt - base, 32'd2);

        // Asynchronous reset with an op in flight
        issue(3'b001, 32'h3F800000, 32'h40000000, 5'd26);
        cycle(acc);
        in_valid = 1'b0;
        in_ready = 1'b0;
        cycle(acc);
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'h0);
        check("arst_tag", {27'b0, out_tag}, 32'h0);
        q.delete();
        sticky_model = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_ready", {31'b0, out_ready}, 32'h1);

        // Randomized traffic with stalls, occasional flushes and sticky clears
        for (int c = 0; c < 400; c++) begin
            logic [31:0] a;
            a = rnd_f($urandom);
            issue(ops[$urandom_range(0, 7)], a, rnd_f(a), $urandom_range(0, 31));
            in_valid = ($urandom_range(0, 9) < 7);
            in_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 99) < 3);
            nv_clr   = ($urandom_range(0, 99) < 5);
            cycle(acc);
        end
        idle();
        in_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) cycle(acc);
        check("drain_empty", q.size(), 32'd0);
        cycle(acc);
        check("drain_valid", {31'b0, out_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
